// File: rtl/physical_memory_responder.sv
// Line-granular pmem responder: one request at a time, fixed latency,
// single-cycle resp pulse, registered read line and traffic counters.
module physical_memory_responder #(
    parameter int LATENCY = 10,
    parameter int LINES   = 256,
    parameter int IDX_W   = $clog2(LINES)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         pmem_read,
    input  logic         pmem_write,
    input  logic [15:0]  pmem_address,
    input  logic [127:0] pmem_wdata,
    output logic [127:0] pmem_rdata,
    output logic         pmem_resp,
    output logic [15:0]  read_count,
    output logic [15:0]  write_count
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESPOND
    } state_e;

    localparam logic [7:0] LAT8 = 8'(LATENCY);

    state_e             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               op_write_q, op_write_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [127:0]       wdata_q, wdata_d;
    logic [127:0]       rdata_q, rdata_d;
    logic [15:0]        rcnt_q, rcnt_d;
    logic [15:0]        wcnt_q, wcnt_d;
    logic               mem_we;

    // Contents survive reset; only elaboration zeroes them.
    logic [127:0]       mem_q [0:LINES-1] = '{default: '0};

    // Offset and alias bits of the address carry no meaning here.
    logic               unused_addr;
    assign unused_addr = ^pmem_address;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_write_d = op_write_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        rcnt_d     = rcnt_q;
        wcnt_d     = wcnt_q;
        mem_we     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pmem_read | pmem_write) begin
                    op_write_d = pmem_write;
                    idx_d      = pmem_address[4+IDX_W-1:4];
                    wdata_d    = pmem_wdata;
                    cnt_d      = LAT8;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == 8'd1) begin
                    state_d = RESPOND;
                    if (op_write_q) begin
                        mem_we = 1'b1;
                        if (wcnt_q != 16'hFFFF) wcnt_d = wcnt_q + 16'd1;
                    end else begin
                        rdata_d = mem_q[idx_q];
                        if (rcnt_q != 16'hFFFF) rcnt_d = rcnt_q + 16'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_write_q <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            rcnt_q     <= '0;
            wcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_write_q <= op_write_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            rcnt_q     <= rcnt_d;
            wcnt_q     <= wcnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[idx_q] <= wdata_q;
    end

    assign pmem_resp   = (state_q == RESPOND);
    assign pmem_rdata  = rdata_q;
    assign read_count  = rcnt_q;
    assign write_count = wcnt_q;

endmodule

// File: tb/tb_physical_memory_responder.sv
// Self-checking bench for physical_memory_responder: directed table,
// hand-written corner sequences and randomized traffic vs a line model.
module tb_physical_memory_responder;

    localparam int LAT = 10;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;
    logic [15:0]  read_count;
    logic [15:0]  write_count;

    physical_memory_responder #(.LATENCY(LAT), .LINES(256)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .read_count   (read_count),
        .write_count  (write_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: plain array of lines plus counters.
    logic [127:0] mdl_mem [256];
    logic [127:0] mdl_rdata;
    int           mdl_rc;
    int           mdl_wc;

    typedef struct {
        bit           wr;
        bit           rd;
        logic [15:0]  addr;
        logic [127:0] wdata;
        bit           chk;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void mdl_apply(input bit wr, input bit rd,
                                      input logic [15:0] addr,
                                      input logic [127:0] wd);
        int idx;
        idx = (int'(addr) / 16) % 256;
        if (wr) begin
            mdl_mem[idx] = wd;
            if (mdl_wc < 65535) mdl_wc++;
        end else if (rd) begin
            mdl_rdata = mdl_mem[idx];
            if (mdl_rc < 65535) mdl_rc++;
        end
    endfunction

    // Called #1 after a posedge with the DUT idle; returns #1 after the
    // edge that follows the resp pulse, strobes low.
    task automatic run_txn(input bit wr, input bit rd,
                           input logic [15:0] addr, input logic [127:0] wd,
                           input int perturb_edge,
                           input logic [15:0] new_addr);
        int edges;
        pmem_write   = wr;
        pmem_read    = rd;
        pmem_address = addr;
        pmem_wdata   = wd;
        @(posedge clk);
        edges = 0;
        while (edges < LAT + 20) begin
            @(posedge clk);
            #1;
            edges++;
            if (perturb_edge != 0 && edges == perturb_edge) begin
                pmem_address = new_addr;
                pmem_wdata   = ~wd;
                pmem_write   = 1'b0;
                pmem_read    = 1'b0;
            end
            if (pmem_resp) break;
        end
        chk("latency", 128'(edges), 128'(LAT));
        mdl_apply(wr, rd, addr, wd);
        chk("rdata", pmem_rdata, mdl_rdata);
        chk("read_count", 128'(read_count), 128'(mdl_rc));
        chk("write_count", 128'(write_count), 128'(mdl_wc));
        @(posedge clk);
        #1;
        chk("resp_width", 128'(pmem_resp), 128'(0));
        chk("rdata_hold", pmem_rdata, mdl_rdata);
        pmem_write = 1'b0;
        pmem_read  = 1'b0;
    endtask

    initial begin
        logic [127:0] z_line;
        logic [127:0] y_line;
        logic [127:0] w_line;
        bit           seen;

        for (int i = 0; i < 256; i++) mdl_mem[i] = '0;
        mdl_rdata = '0;
        mdl_rc    = 0;
        mdl_wc    = 0;

        vecs[0] = '{1, 0, 16'h0040,
                    128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 0, '0};
        vecs[1] = '{0, 1, 16'h004E, '0, 1,
                    128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210};
        vecs[2] = '{1, 0, 16'h1000, 128'hA5A5_0000_1111_2222_3333_4444_5555_6666,
                    0, '0};
        vecs[3] = '{0, 1, 16'h0000, '0, 1,
                    128'hA5A5_0000_1111_2222_3333_4444_5555_6666};
        vecs[4] = '{1, 0, 16'h0100, 128'hDEAD_BEEF_CAFE_F00D_0BAD_F00D_1234_5678,
                    0, '0};
        vecs[5] = '{0, 1, 16'h0200, '0, 1, 128'h0};
        vecs[6] = '{0, 1, 16'h0100, '0, 1,
                    128'hDEAD_BEEF_CAFE_F00D_0BAD_F00D_1234_5678};

        rst_n        = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_resp", 128'(pmem_resp), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (pmem_resp) seen = 1'b1;
        end
        chk("idle_resp", 128'(seen), 128'(0));
        chk("idle_rdata", pmem_rdata, 128'h0);
        chk("idle_read_count", 128'(read_count), 128'(0));
        chk("idle_write_count", 128'(write_count), 128'(0));

        // Directed table, back to back: each entry is raised in the cycle
        // after the previous resp, so 4->5 is the writeback/fill handoff.
        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata,
                    0, '0);
            if (vecs[i].chk) chk($sformatf("vec%0d_data", i),
                                 pmem_rdata, vecs[i].exp);
        end
        chk("vec_write_count", 128'(write_count), 128'(3));
        chk("vec_read_count", 128'(read_count), 128'(4));

        // Both strobes, then address/strobes disturbed mid-BUSY.
        w_line = 128'h7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE;
        run_txn(1, 1, 16'h0500, w_line, 3, 16'h0600);
        chk("perturb_read_count", 128'(read_count), 128'(4));
        run_txn(0, 1, 16'h0500, '0, 0, '0);
        chk("perturb_commit", pmem_rdata, w_line);
        run_txn(0, 1, 16'h0600, '0, 0, '0);
        chk("perturb_other_line", pmem_rdata, 128'h0);

        // Reset abort mid-write.
        z_line = 128'h1234_1234_1234_1234_5678_5678_5678_5678;
        y_line = 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000;
        run_txn(1, 0, 16'h0300, z_line, 0, '0);
        pmem_write   = 1'b1;
        pmem_address = 16'h0300;
        pmem_wdata   = y_line;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #1;
        rst_n      = 1'b0;
        pmem_write = 1'b0;
        #1;
        chk("abort_read_count", 128'(read_count), 128'(0));
        chk("abort_write_count", 128'(write_count), 128'(0));
        chk("abort_rdata", pmem_rdata, 128'h0);
        mdl_rc = 0;
        mdl_wc = 0;
        mdl_rdata = '0;
        seen = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (pmem_resp) seen = 1'b1;
        end
        chk("abort_no_resp", 128'(seen), 128'(0));
        run_txn(0, 1, 16'h0300, '0, 0, '0);
        chk("abort_line_kept", pmem_rdata, z_line);

        // Randomized traffic over a few lines with aliased upper bits.
        for (int i = 0; i < 60; i++) begin
            logic [15:0]  a;
            logic [127:0] d;
            int           op;
            a  = {4'($urandom), 5'b0, 3'($urandom), 4'($urandom)};
            d  = {$urandom, $urandom, $urandom, $urandom};
            op = $urandom_range(0, 2);
            run_txn(op != 1, op != 0, a, d, 0, '0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
